// File: rtl/kgp_diff_pkg.sv
// Shared constants and FSM encoding for the KGP_RISC diff unit and its
// diff_apply_unit decoding counterpart.
package kgp_diff_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned POS_W           = 6;
  localparam int unsigned ILLEGAL_POS_MIN = WORD_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FIN   = 2'd2
  } state_t;

endpackage

// File: rtl/diff_apply_unit_if.sv
// Start/position handshake and result bundle for diff_apply_unit.
interface diff_apply_unit_if;
  import kgp_diff_pkg::*;

  logic              start;
  logic              empty;
  logic [WORD_W-1:0] base;
  logic              pos_valid;
  logic              pos_ready;
  logic [POS_W-1:0]  pos;
  logic              pos_last;
  logic [WORD_W-1:0] out;
  logic [POS_W-1:0]  count;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, empty, base, pos_valid, pos, pos_last,
    input  pos_ready, out, count, busy, done, err
  );

  modport slave (
    input  start, empty, base, pos_valid, pos, pos_last,
    output pos_ready, out, count, busy, done, err
  );

endinterface

// File: rtl/pos_onehot_dec.sv
// Position code to one-hot bit mask; positions at or above WORD_W give an
// all-zero mask with in_range low.
module pos_onehot_dec
  import kgp_diff_pkg::*;
(
  input  logic [POS_W-1:0]  pos,
  output logic [WORD_W-1:0] onehot,
  output logic              in_range
);

  always_comb begin
    in_range = (pos < POS_W'(ILLEGAL_POS_MIN));
    onehot   = in_range ? (WORD_W'(1) << pos) : '0;
  end

endmodule

// File: rtl/diff_apply_unit.sv
// Rebuilds a word from a base plus a stream of bit positions to toggle.
// Optional duplicate-position detection: define DIFF_APPLY_DUP_CHECK_EN.
module diff_apply_unit
  import kgp_diff_pkg::*;
#(
  parameter int unsigned MAX_POS = 32
) (
  input logic              clk,
  input logic              rst,
  diff_apply_unit_if.slave bus
);

  localparam int unsigned HS_W = $clog2(MAX_POS + 1);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] out_q, out_d;
  logic [POS_W-1:0]  count_q, count_d;
  logic [HS_W-1:0]   hs_q, hs_d;
  logic              err_q, err_d;

  logic [WORD_W-1:0] pos_mask;
  logic              pos_in_range;
  logic              pos_dup;

  pos_onehot_dec u_dec (
    .pos      (bus.pos),
    .onehot   (pos_mask),
    .in_range (pos_in_range)
  );

`ifdef DIFF_APPLY_DUP_CHECK_EN
  logic [WORD_W-1:0] seen_q, seen_d;
  assign pos_dup = |(seen_q & pos_mask);
`else
  assign pos_dup = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      out_q   <= '0;
      count_q <= '0;
      hs_q    <= '0;
      err_q   <= 1'b0;
`ifdef DIFF_APPLY_DUP_CHECK_EN
      seen_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      count_q <= count_d;
      hs_q    <= hs_d;
      err_q   <= err_d;
`ifdef DIFF_APPLY_DUP_CHECK_EN
      seen_q  <= seen_d;
`endif
    end
  end

  // out is loaded with the final accumulator on entry to FIN, so it is
  // already valid in the cycle where done is high.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    out_d   = out_q;
    count_d = count_q;
    hs_d    = hs_q;
    err_d   = err_q;
`ifdef DIFF_APPLY_DUP_CHECK_EN
    seen_d  = seen_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = bus.base;
          count_d = '0;
          hs_d    = '0;
          err_d   = 1'b0;
`ifdef DIFF_APPLY_DUP_CHECK_EN
          seen_d  = '0;
`endif
          if (bus.empty) begin
            state_d = FIN;
            out_d   = bus.base;
          end else begin
            state_d = ACCUM;
          end
        end
      end

      ACCUM: begin
        if (bus.pos_valid) begin
          hs_d = hs_q + HS_W'(1);
          if (!pos_in_range || pos_dup) begin
            err_d = 1'b1;
          end else begin
            acc_d   = acc_q ^ pos_mask;
            count_d = count_q + POS_W'(1);
`ifdef DIFF_APPLY_DUP_CHECK_EN
            seen_d  = seen_q | pos_mask;
`endif
          end

          if (bus.pos_last) begin
            state_d = FIN;
          end else if (hs_q == HS_W'(MAX_POS - 1)) begin
            err_d   = 1'b1;
            state_d = FIN;
          end

          if (state_d == FIN) begin
            out_d = acc_d;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.pos_ready = (state_q == ACCUM);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == FIN);
  assign bus.out       = out_q;
  assign bus.count     = count_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_diff_apply_unit.sv
// Directed self-checking bench for diff_apply_unit.
module tb_diff_apply_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  diff_apply_unit_if dut_if ();

  diff_apply_unit #(.MAX_POS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_txn(input logic [31:0] b, input logic emp);
    dut_if.start = 1'b1;
    dut_if.base  = b;
    dut_if.empty = emp;
    @(negedge clk);
    dut_if.start = 1'b0;
    dut_if.empty = 1'b0;
  endtask

  task automatic send_pos(input logic [5:0] p, input logic last);
    int g;
    g = 0;
    while (!dut_if.pos_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) check("ready_timeout", 32'd0, 32'd1);
    dut_if.pos_valid = 1'b1;
    dut_if.pos       = p;
    dut_if.pos_last  = last;
    @(negedge clk);
    dut_if.pos_valid = 1'b0;
    dut_if.pos_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [31:0] o,
                              input logic [31:0] c, input logic e);
    check({tag, "_done"}, 32'(dut_if.done), 32'd1);
    check({tag, "_out"}, dut_if.out, o);
    check({tag, "_count"}, 32'(dut_if.count), c);
    check({tag, "_err"}, 32'(dut_if.err), 32'(e));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(dut_if.done), 32'd0);
    check({tag, "_idle"}, 32'(dut_if.busy), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    dut_if.start     = 1'b0;
    dut_if.empty     = 1'b0;
    dut_if.base      = '0;
    dut_if.pos_valid = 1'b0;
    dut_if.pos       = '0;
    dut_if.pos_last  = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_out", dut_if.out, 32'd0);
    check("rst_count", 32'(dut_if.count), 32'd0);
    check("rst_err", 32'(dut_if.err), 32'd0);
    check("rst_done", 32'(dut_if.done), 32'd0);
    check("rst_ready", 32'(dut_if.pos_ready), 32'd0);
    check("rst_busy", 32'(dut_if.busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // basic reconstruction: 0x140 ^ bit7 ^ bit8 = 0xC0
    start_txn(32'h140, 1'b0);
    check("recon_ready_lat", 32'(dut_if.pos_ready), 32'd1);
    check("recon_busy", 32'(dut_if.busy), 32'd1);
    send_pos(6'd7, 1'b0);
    check("recon_mid_done", 32'(dut_if.done), 32'd0);
    send_pos(6'd8, 1'b1);
    check_result("recon", 32'hC0, 32'd2, 1'b0);
    check("recon_hold", dut_if.out, 32'hC0);

    // MSB toggle
    start_txn(32'h8000_0000, 1'b0);
    send_pos(6'd31, 1'b1);
    check_result("msb", 32'h0, 32'd1, 1'b0);

    start_txn(32'h1, 1'b0);
    send_pos(6'd0, 1'b0);
    send_pos(6'd1, 1'b1);
    check_result("lsb", 32'h2, 32'd2, 1'b0);

    // empty transaction, stray pos_valid must be ignored
    dut_if.pos_valid = 1'b1;
    dut_if.pos       = 6'd4;
    check("empty_ready_pre", 32'(dut_if.pos_ready), 32'd0);
    start_txn(32'hDEAD_BEEF, 1'b1);
    check("empty_ready", 32'(dut_if.pos_ready), 32'd0);
    check_result("empty", 32'hDEAD_BEEF, 32'd0, 1'b0);
    dut_if.pos_valid = 1'b0;

    // illegal position
    start_txn(32'h0, 1'b0);
    send_pos(6'd40, 1'b0);
    check("illegal_err_early", 32'(dut_if.err), 32'd1);
    send_pos(6'd3, 1'b1);
    check_result("illegal", 32'h8, 32'd1, 1'b1);

    // duplicates; err from the previous transaction must be cleared
    start_txn(32'h0, 1'b0);
    check("dup_err_clear", 32'(dut_if.err), 32'd0);
    send_pos(6'd5, 1'b0);
    send_pos(6'd5, 1'b1);
`ifdef DIFF_APPLY_DUP_CHECK_EN
    check_result("dup", 32'h20, 32'd1, 1'b1);
`else
    check_result("dup", 32'h0, 32'd2, 1'b0);
`endif

    // overflow: 32 handshakes without pos_last
    start_txn(32'h0, 1'b0);
    for (int i = 0; i < 31; i++) send_pos(6'(i), 1'b0);
    check("ovf_no_early_done", 32'(dut_if.done), 32'd0);
    check("ovf_still_ready", 32'(dut_if.pos_ready), 32'd1);
    send_pos(6'd31, 1'b0);
    check("ovf_ready_drop", 32'(dut_if.pos_ready), 32'd0);
    check_result("ovf", 32'hFFFF_FFFF, 32'd32, 1'b1);

    start_txn(32'h1234, 1'b0);
    send_pos(6'd0, 1'b1);
    check_result("clean", 32'h1235, 32'd1, 1'b0);

    // reset in the middle of a transaction
    start_txn(32'hFF, 1'b0);
    send_pos(6'd0, 1'b0);
    send_pos(6'd1, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_busy", 32'(dut_if.busy), 32'd0);
    check("mrst_out", dut_if.out, 32'd0);
    check("mrst_count", 32'(dut_if.count), 32'd0);
    check("mrst_done", 32'(dut_if.done), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_done_after", 32'(dut_if.done), 32'd0);

    // start while busy is ignored
    start_txn(32'h100, 1'b0);
    start_txn(32'hFFFF_FFFF, 1'b0);
    check("busy_start_ready", 32'(dut_if.pos_ready), 32'd1);
    send_pos(6'd0, 1'b1);
    check_result("busy_start", 32'h101, 32'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
